// File: rtl/xulie_pkg.sv
// Shared types and defaults for the "10010" detector stimulus sequencer.
package xulie_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Detector states, named by the longest matched prefix of "10010".
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } det_state_t;

endpackage

// File: rtl/xulie_if.sv
// Control/status bundle between the switch/key logic, the sequencer and the detector.
interface xulie_if
    import xulie_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [3:0]       loops;
    logic             z;
    logic             x;
    logic             det_rst_n;
    logic             busy;
    logic             done;
    logic [CW-1:0]    hit_cnt;
    logic [CW-1:0]    first_hit;

    modport master (
        output start, abort, pattern, loops, z,
        input  x, det_rst_n, busy, done, hit_cnt, first_hit
    );

    modport slave (
        input  start, abort, pattern, loops, z,
        output x, det_rst_n, busy, done, hit_cnt, first_hit
    );
endinterface

// File: rtl/xulie_hitcnt.sv
// Saturating detection counter with capture of the run index of the first detection.
module xulie_hitcnt
    import xulie_pkg::*;
#(
    parameter int CW = CW_DEF
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          hit,
    input  logic [CW-1:0] idx,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] first
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] first_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            first_q <= '0;
        end else if (clr) begin
            cnt_q   <= '0;
            first_q <= '0;
        end else if (en && hit) begin
            if (cnt_q == '0) begin
                first_q <= idx;
            end
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt   = cnt_q;
    assign first = first_q;

endmodule

// File: rtl/xulie_ctrl.sv
// Streams a latched test word MSB-first into the "10010" detector and tallies its hits.
//   state | meaning
//   IDLE  | x=0, waiting for start
//   CLR   | one cycle holding the detector in reset
//   RUN   | shifting bits out, counting z==0 cycles
//   DONE  | one-cycle completion pulse
module xulie_ctrl
    import xulie_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF
)
(
    input  logic   CLOCK_50,
    input  logic   rst,
    xulie_if.slave bus
);

    localparam int BW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("xulie_ctrl: WIDTH must be within 2..16");
    end
    if (WIDTH * 16 > (1 << CW)) begin : g_bad_cw
        $error("xulie_ctrl: CW too narrow for the longest run");
    end

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [3:0]       pass_q;
    logic [BW-1:0]    bit_q;
    logic [CW-1:0]    cyc_q;
    logic             x_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] sh_rot;
    logic             last_bit;

    assign sh_rot   = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
    assign last_bit = (bit_q == BW'(WIDTH - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            pass_q  <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    x_q <= 1'b0;
                    if (bus.start) begin
                        sh_q    <= bus.pattern;
                        pass_q  <= bus.loops;
                        busy_q  <= 1'b1;
                        state_q <= CLR;
                    end
                end
                CLR: begin
                    bit_q <= '0;
                    cyc_q <= '0;
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        x_q     <= sh_q[WIDTH-1];
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // x always mirrors the MSB of the rotating word while running
                    sh_q  <= sh_rot;
                    cyc_q <= cyc_q + 1'b1;
                    bit_q <= last_bit ? '0 : bit_q + 1'b1;
                    x_q   <= sh_rot[WIDTH-1];
                    if (bus.abort) begin
                        x_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (last_bit) begin
                        if (pass_q != 4'd0) begin
                            pass_q <= pass_q - 4'd1;
                        end else begin
                            x_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    x_q     <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    x_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Hits are taken in every RUN cycle, including one that also sees abort.
    xulie_hitcnt #(
        .CW (CW)
    ) u_hitcnt (
        .clk   (CLOCK_50),
        .rst_n (rst),
        .clr   ((state_q == IDLE) && bus.start),
        .en    (state_q == RUN),
        .hit   (~bus.z),
        .idx   (cyc_q),
        .cnt   (bus.hit_cnt),
        .first (bus.first_hit)
    );

    assign bus.x         = x_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.det_rst_n = rst & (state_q != CLR);

endmodule
